// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux stage: steps the selects through channels 0..3,
// samples Y once per channel after a settle time and publishes a 4-bit frame.
module mux4_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CONT,
  input  logic       Y,
  output logic       S0,
  output logic       S1,
  output logic [3:0] Q,
  output logic       VALID,
  output logic       BUSY
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CH_W  = 2;
  localparam bit          SKIP_SETTLE = (SETTLE == 0);
  localparam logic [CNT_W-1:0] RELOAD = SKIP_SETTLE ? '0 : CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  // A zero settle time enters each channel directly in its sample cycle.
  localparam state_t ENTRY_STATE = SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;

  state_t           state, state_d;
  logic [CH_W-1:0]  ch, ch_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       shadow, shadow_d;
  logic [3:0]       q_d;
  logic             valid_d;
  logic             busy_d;

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      ch     <= '0;
      cnt    <= '0;
      shadow <= '0;
      Q      <= '0;
      VALID  <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_d;
      ch     <= ch_d;
      cnt    <= cnt_d;
      shadow <= shadow_d;
      Q      <= q_d;
      VALID  <= valid_d;
      BUSY   <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    ch_d     = ch;
    cnt_d    = cnt;
    shadow_d = shadow;
    q_d      = Q;
    valid_d  = 1'b0;
    busy_d   = BUSY;

    case (state)
      ST_IDLE: begin
        ch_d   = '0;
        busy_d = 1'b0;
        if (START) begin
          state_d = ENTRY_STATE;
          cnt_d   = RELOAD;
          busy_d  = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (cnt == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (ch != CH_W'(3)) begin
          shadow_d[ch] = Y;
          ch_d         = ch + CH_W'(1);
          state_d      = ENTRY_STATE;
          cnt_d        = RELOAD;
        end else begin
          // Channel 3 goes straight into Q so the whole frame lands in one edge.
          q_d     = {Y, shadow};
          valid_d = 1'b1;
          ch_d    = '0;
          if (CONT) begin
            state_d = ENTRY_STATE;
            cnt_d   = RELOAD;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign S0 = ch[1];
  assign S1 = ch[0];

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: three instances (SETTLE = 0, 1, 3), each driving a
// behavioural 4:1 mux, checked with a frame table plus hand-written sequences.
module tb_mux4_scan_ctrl;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      start_v = '0;
  logic [2:0]      cont_v = '0;
  logic [2:0][3:0] x_v = '0;
  wire  [2:0]      s0_v, s1_v, valid_v, busy_v, y_v;
  wire  [2:0][3:0] q_v;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4_scan_ctrl #(.SETTLE(0)) dut0 (
    .CLK(clk), .RST(rst), .START(start_v[0]), .CONT(cont_v[0]), .Y(y_v[0]),
    .S0(s0_v[0]), .S1(s1_v[0]), .Q(q_v[0]), .VALID(valid_v[0]), .BUSY(busy_v[0]));
  mux4_scan_ctrl #(.SETTLE(1)) dut1 (
    .CLK(clk), .RST(rst), .START(start_v[1]), .CONT(cont_v[1]), .Y(y_v[1]),
    .S0(s0_v[1]), .S1(s1_v[1]), .Q(q_v[1]), .VALID(valid_v[1]), .BUSY(busy_v[1]));
  mux4_scan_ctrl #(.SETTLE(3)) dut3 (
    .CLK(clk), .RST(rst), .START(start_v[2]), .CONT(cont_v[2]), .Y(y_v[2]),
    .S0(s0_v[2]), .S1(s1_v[2]), .Q(q_v[2]), .VALID(valid_v[2]), .BUSY(busy_v[2]));

  // Behavioural mux4: Y = X[{S0,S1}]
  assign y_v[0] = x_v[0][{s0_v[0], s1_v[0]}];
  assign y_v[1] = x_v[1][{s0_v[1], s1_v[1]}];
  assign y_v[2] = x_v[2][{s0_v[2], s1_v[2]}];

  typedef struct {
    int         idx;
    logic [3:0] x;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int settle_of(input int idx);
    case (idx)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input int idx);
    return {s0_v[idx], s1_v[idx]};
  endfunction

  // Single-shot frame with full per-cycle timing checks.
  task automatic run_frame(input int idx, input logic [3:0] x, input logic [3:0] exp_q);
    int per;
    int k;
    logic [1:0] exp_sel;
    per = settle_of(idx) + 1;
    k   = 4 * per;
    x_v[idx]     = x;
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
    for (int t = 0; t <= k; t++) begin
      if (t > 0) tick();
      exp_sel = (t < k) ? 2'(t / per) : 2'd0;
      chk($sformatf("frame%0d_sel_t%0d", idx, t), 32'(sel_of(idx)), 32'(exp_sel));
      chk($sformatf("frame%0d_valid_t%0d", idx, t), 32'(valid_v[idx]), 32'(t == k));
      chk($sformatf("frame%0d_busy_t%0d", idx, t), 32'(busy_v[idx]), 32'(t < k));
    end
    chk($sformatf("frame%0d_q", idx), 32'(q_v[idx]), 32'(exp_q));
    tick();
    chk($sformatf("frame%0d_valid_after", idx), 32'(valid_v[idx]), 32'd0);
    chk($sformatf("frame%0d_q_hold", idx), 32'(q_v[idx]), 32'(exp_q));
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_sel%0d", tag, i), 32'(sel_of(i)), 32'd0);
      chk($sformatf("%s_q%0d", tag, i), 32'(q_v[i]), 32'd0);
      chk($sformatf("%s_valid%0d", tag, i), 32'(valid_v[i]), 32'd0);
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy_v[i]), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    logic exp_v;

    vecs[0] = '{1, 4'b1010, 4'b1010};
    vecs[1] = '{1, 4'b0101, 4'b0101};
    vecs[2] = '{0, 4'b1001, 4'b1001};
    vecs[3] = '{0, 4'b0110, 4'b0110};
    vecs[4] = '{2, 4'b1111, 4'b1111};
    vecs[5] = '{2, 4'b0001, 4'b0001};

    rst = 1'b1;
    tick();
    tick();
    chk_reset_state("por");
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_frame(vecs[i].idx, vecs[i].x, vecs[i].exp_q);

    // Reset from idle with non-zero Q.
    rst = 1'b1;
    tick();
    tick();
    chk_reset_state("idle_rst");
    rst = 1'b0;
    tick();

    // Y glitch during ch1 settle cycles must not reach Q (SETTLE=3).
    x_v[2]     = 4'b0101;
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    vcount = 0;
    for (int t = 1; t <= 22; t++) begin
      tick();
      vcount += int'(valid_v[2]);
      if (t == 4) x_v[2][1] = 1'b1;
      if (t == 6) x_v[2][1] = 1'b0;
      if (t == 16) chk("mask_q", 32'(q_v[2]), 32'b0101);
    end
    chk("mask_valid_count", 32'(vcount), 32'd1);

    // Continuous mode, then CONT dropped mid third frame (SETTLE=1).
    x_v[1]     = 4'b0011;
    cont_v[1]  = 1'b1;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      exp_v = (t % 8 == 0) && (t <= 24);
      chk($sformatf("cont_valid_t%0d", t), 32'(valid_v[1]), 32'(exp_v));
      if (exp_v) chk($sformatf("cont_q_t%0d", t), 32'(q_v[1]), (t == 8) ? 32'b0011 : 32'b1100);
      if (t == 23) chk("cont_busy_t23", 32'(busy_v[1]), 32'd1);
      if (t == 24) chk("cont_busy_t24", 32'(busy_v[1]), 32'd0);
      if (t == 8) x_v[1] = 4'b1100;
      if (t == 18) cont_v[1] = 1'b0;
    end

    // START re-asserted at ch2 is ignored; period unchanged.
    x_v[1]     = 4'b0110;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("abuse_valid_t%0d", t), 32'(valid_v[1]), 32'(t == 8));
      if (t == 8) chk("abuse_q", 32'(q_v[1]), 32'b0110);
      if (t == 4) start_v[1] = 1'b1;
      if (t == 5) start_v[1] = 1'b0;
    end

    // Reset at ch2 discards the frame.
    x_v[1]     = 4'b1001;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    for (int t = 1; t <= 4; t++) tick();
    chk("midrst_sel_before", 32'(sel_of(1)), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("midrst");
    vcount = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      vcount += int'(valid_v[1]);
    end
    chk("midrst_no_valid", 32'(vcount), 32'd0);
    run_frame(1, 4'b1001, 4'b1001);

    // START held high across a frame end restarts at the next edge (SETTLE=0).
    x_v[0]     = 4'b0111;
    start_v[0] = 1'b1;
    tick();
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("held_valid_t%0d", t), 32'(valid_v[0]), 32'((t == 4) || (t == 9)));
      if (t == 4) chk("held_busy_t4", 32'(busy_v[0]), 32'd0);
      if (t == 5) begin
        chk("held_busy_t5", 32'(busy_v[0]), 32'd1);
        start_v[0] = 1'b0;
      end
      if (t == 9) chk("held_q", 32'(q_v[0]), 32'b0111);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
